axi_wr_arb_sequencer: RTL and testbench

- Shares one AXI write port between N_INP requesters.
- Arbitrates AW beats round-robin and records each winner's index in an in-order ID FIFO.
- Steers W beats from the recorded requester until WLAST, so W data always follows AW grant order.
- Sits between the per-requester AXI write channels (cache, PTW, accelerator) and the single system write port.

---
 rtl/axi_wr_arb_sequencer.sv | 143 ++++++++++++++
 tb/tb_axi_wr_arb_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_wr_arb_sequencer.sv
// rtl/axi_wr_arb_sequencer.sv - round-robin AW arbiter with in-order W steering
// Grants AW beats round-robin, queues winner indices, and routes W bursts in grant order.
module axi_wr_arb_sequencer #(
  parameter int N_INP      = 4,
  parameter int AW_WIDTH   = 64,
  parameter int W_WIDTH    = 73,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        flush_i,
  input  logic [N_INP-1:0]            aw_valid_i,
  output logic [N_INP-1:0]            aw_ready_o,
  input  logic [N_INP*AW_WIDTH-1:0]   aw_data_i,
  output logic                        aw_valid_o,
  input  logic                        aw_ready_i,
  output logic [AW_WIDTH-1:0]         aw_data_o,
  input  logic [N_INP-1:0]            w_valid_i,
  output logic [N_INP-1:0]            w_ready_o,
  input  logic [N_INP*W_WIDTH-1:0]    w_data_i,
  input  logic [N_INP-1:0]            w_last_i,
  output logic                        w_valid_o,
  input  logic                        w_ready_i,
  output logic [W_WIDTH-1:0]          w_data_o,
  output logic                        w_last_o,
  output logic                        busy_o
);

  localparam int IDX_W = $clog2(N_INP);
  localparam int SUM_W = IDX_W + 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] lock_idx;
  logic             lock;
  logic [IDX_W-1:0] id_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic [IDX_W-1:0] cand;
  logic             cand_found;
  logic [SUM_W-1:0] scan_sum;
  logic [IDX_W-1:0] head;
  logic             full;
  logic             empty;
  logic             active;
  logic             w_route;
  logic             aw_fire;
  logic             w_fire;

  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign active  = rst_ni & ~flush_i;
  assign head    = id_mem[rd_ptr];
  assign busy_o  = (count != '0);

  // Scan downward so the lowest offset from rr_ptr is the last (winning) match.
  always_comb begin
    cand       = '0;
    cand_found = 1'b0;
    scan_sum   = '0;
    if (lock) begin
      cand       = lock_idx;
      cand_found = aw_valid_i[lock_idx];
    end else begin
      for (int i = N_INP - 1; i >= 0; i--) begin
        scan_sum = {1'b0, rr_ptr} + SUM_W'(i);
        if (scan_sum >= SUM_W'(N_INP)) scan_sum = scan_sum - SUM_W'(N_INP);
        if (aw_valid_i[scan_sum[IDX_W-1:0]]) begin
          cand       = scan_sum[IDX_W-1:0];
          cand_found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    aw_valid_o = active & cand_found & ~full;
    aw_ready_o = '0;
    aw_data_o  = '0;
    if (aw_valid_o) begin
      aw_ready_o[cand] = aw_ready_i;
      aw_data_o        = aw_data_i[cand*AW_WIDTH +: AW_WIDTH];
    end
  end

  // A push into an empty FIFO only exposes its head on the next cycle.
  assign w_route = active & ~empty;

  always_comb begin
    w_valid_o = 1'b0;
    w_last_o  = 1'b0;
    w_data_o  = '0;
    w_ready_o = '0;
    if (w_route) begin
      w_valid_o       = w_valid_i[head];
      w_last_o        = w_last_i[head];
      w_data_o        = w_data_i[head*W_WIDTH +: W_WIDTH];
      w_ready_o[head] = w_ready_i;
    end
  end

  assign aw_fire = aw_valid_o & aw_ready_i;
  assign w_fire  = w_valid_o & w_ready_i & w_last_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr   <= '0;
      lock     <= 1'b0;
      lock_idx <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) id_mem[i] <= '0;
    end else if (flush_i) begin
      rr_ptr <= '0;
      lock   <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (aw_fire) begin
        id_mem[wr_ptr] <= cand;
        wr_ptr         <= wr_ptr + 1'b1;
        rr_ptr         <= (cand == IDX_W'(N_INP - 1)) ? '0 : cand + 1'b1;
        lock           <= 1'b0;
      end else if (aw_valid_o) begin
        // Hold the presented winner so aw_data_o stays stable until accepted.
        lock     <= 1'b1;
        lock_idx <= cand;
      end
      if (w_fire) rd_ptr <= rd_ptr + 1'b1;
      case ({aw_fire, w_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_wr_arb_sequencer.sv
// tb/tb_axi_wr_arb_sequencer.sv - self-checking bench for axi_wr_arb_sequencer
module tb_axi_wr_arb_sequencer;

  localparam int N_INP      = 4;
  localparam int AW_WIDTH   = 64;
  localparam int W_WIDTH    = 73;
  localparam int FIFO_DEPTH = 4;

  logic                      clk_i = 1'b0;
  logic                      rst_ni;
  logic                      flush_i;
  logic [N_INP-1:0]          aw_valid_i;
  logic [N_INP-1:0]          aw_ready_o;
  logic [N_INP*AW_WIDTH-1:0] aw_data_i;
  logic                      aw_valid_o;
  logic                      aw_ready_i;
  logic [AW_WIDTH-1:0]       aw_data_o;
  logic [N_INP-1:0]          w_valid_i;
  logic [N_INP-1:0]          w_ready_o;
  logic [N_INP*W_WIDTH-1:0]  w_data_i;
  logic [N_INP-1:0]          w_last_i;
  logic                      w_valid_o;
  logic                      w_ready_i;
  logic [W_WIDTH-1:0]        w_data_o;
  logic                      w_last_o;
  logic                      busy_o;

  axi_wr_arb_sequencer #(
    .N_INP(N_INP), .AW_WIDTH(AW_WIDTH), .W_WIDTH(W_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o), .aw_data_i(aw_data_i),
    .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i), .aw_data_o(aw_data_o),
    .w_valid_i(w_valid_i), .w_ready_o(w_ready_o), .w_data_i(w_data_i), .w_last_i(w_last_i),
    .w_valid_o(w_valid_o), .w_ready_i(w_ready_i), .w_data_o(w_data_o), .w_last_o(w_last_o),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [3:0] awv;
    logic       awr;
    logic [3:0] wv;
    logic [3:0] wl;
    logic       wr;
    logic       fl;
    logic       e_awv;
    logic [3:0] e_awr;
    int         e_idx;
    logic       e_wv;
    logic [3:0] e_wr;
    logic       e_wl;
    logic       e_busy;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;
  vec_t tbl[17];
  int aw_q[$];
  logic [W_WIDTH:0] w_q[$];

  function automatic logic [AW_WIDTH-1:0] aw_pay(input int i);
    return {32'hA5A50000 + 32'(i), 32'hC0DE0000 + 32'(i)};
  endfunction

  function automatic logic [W_WIDTH-1:0] w_pay(input int i, input int b);
    return {9'(i), 32'hBEEF0000 + 32'(b), 32'(i * 16 + b)};
  endfunction

  function automatic vec_t mk(input logic [3:0] awv, input logic awr, input logic [3:0] wv,
                              input logic [3:0] wl, input logic wr, input logic fl,
                              input logic e_awv, input logic [3:0] e_awr, input int e_idx,
                              input logic e_wv, input logic [3:0] e_wr, input logic e_wl,
                              input logic e_busy);
    vec_t v;
    v.awv = awv; v.awr = awr; v.wv = wv; v.wl = wl; v.wr = wr; v.fl = fl;
    v.e_awv = e_awv; v.e_awr = e_awr; v.e_idx = e_idx; v.e_wv = e_wv;
    v.e_wr = e_wr; v.e_wl = e_wl; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_w(input int i, input logic v, input int b, input logic l);
    w_valid_i[i] = v;
    w_last_i[i]  = l;
    w_data_i[i*W_WIDTH +: W_WIDTH] = w_pay(i, b);
  endtask

  task automatic do_aw(input int idx);
    int e;
    aw_valid_i = '0;
    aw_valid_i[idx] = 1'b1;
    aw_ready_i = 1'b1;
    aw_q.push_back(idx);
    #1;
    if (aw_valid_o && aw_ready_i) begin
      e = aw_q.pop_front();
      chk("aw_sb data", aw_data_o, aw_pay(e));
    end else begin
      chk("aw_sb valid", aw_valid_o, 1);
    end
    @(posedge clk_i); #1;
    aw_valid_i = '0;
    aw_ready_i = 1'b0;
  endtask

  initial begin
    int b1, b3;
    logic [AW_WIDTH-1:0] exp_aw;
    logic [W_WIDTH:0] ew;

    // Row order builds: fill to full, full+pop, flush, lock-in, flush again.
    tbl[0]  = mk(4'b1111, 1, 4'b0000, 4'b0000, 0, 0, 1, 4'b0001,  0, 0, 4'b0000, 0, 0);
    tbl[1]  = mk(4'b1111, 1, 4'b0000, 4'b0000, 0, 0, 1, 4'b0010,  1, 0, 4'b0000, 0, 1);
    tbl[2]  = mk(4'b1111, 1, 4'b0000, 4'b0000, 0, 0, 1, 4'b0100,  2, 0, 4'b0000, 0, 1);
    tbl[3]  = mk(4'b1111, 1, 4'b0000, 4'b0000, 0, 0, 1, 4'b1000,  3, 0, 4'b0000, 0, 1);
    tbl[4]  = mk(4'b1111, 1, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000, -1, 0, 4'b0000, 0, 1);
    tbl[5]  = mk(4'b0010, 1, 4'b0001, 4'b0001, 1, 0, 0, 4'b0000, -1, 1, 4'b0001, 1, 1);
    tbl[6]  = mk(4'b0010, 1, 4'b0000, 4'b0000, 1, 0, 1, 4'b0010,  1, 0, 4'b0010, 0, 1);
    tbl[7]  = mk(4'b0001, 0, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000, -1, 0, 4'b0000, 0, 1);
    tbl[8]  = mk(4'b0001, 1, 4'b0010, 4'b0000, 1, 1, 0, 4'b0000, -1, 0, 4'b0000, 0, 1);
    tbl[9]  = mk(4'b1000, 0, 4'b0010, 4'b0000, 1, 0, 1, 4'b0000,  3, 0, 4'b0000, 0, 0);
    tbl[10] = mk(4'b1001, 0, 4'b0010, 4'b0000, 1, 0, 1, 4'b0000,  3, 0, 4'b0000, 0, 0);
    tbl[11] = mk(4'b1001, 1, 4'b0010, 4'b0000, 1, 0, 1, 4'b1000,  3, 0, 4'b0000, 0, 0);
    tbl[12] = mk(4'b1001, 0, 4'b0010, 4'b0000, 1, 0, 1, 4'b0000,  0, 0, 4'b1000, 0, 1);
    tbl[13] = mk(4'b0001, 1, 4'b0010, 4'b0000, 1, 0, 1, 4'b0001,  0, 0, 4'b1000, 0, 1);
    tbl[14] = mk(4'b0000, 0, 4'b1000, 4'b0000, 1, 1, 0, 4'b0000, -1, 0, 4'b0000, 0, 1);
    tbl[15] = mk(4'b1001, 0, 4'b0000, 4'b0000, 0, 0, 1, 4'b0000,  0, 0, 4'b0000, 0, 0);
    tbl[16] = mk(4'b0000, 0, 4'b0000, 4'b0000, 0, 1, 0, 4'b0000, -1, 0, 4'b0000, 0, 0);

    rst_ni     = 1'b0;
    flush_i    = 1'b0;
    aw_valid_i = 4'b1111;
    aw_ready_i = 1'b1;
    w_valid_i  = 4'b1111;
    w_last_i   = 4'b1111;
    w_ready_i  = 1'b1;
    for (int i = 0; i < N_INP; i++) begin
      aw_data_i[i*AW_WIDTH +: AW_WIDTH] = aw_pay(i);
      w_data_i[i*W_WIDTH +: W_WIDTH]    = w_pay(i, 0);
    end
    #2;
    chk("reset aw_valid_o", aw_valid_o, 0);
    chk("reset aw_ready_o", aw_ready_o, 0);
    chk("reset aw_data_o", aw_data_o, 0);
    chk("reset w_valid_o", w_valid_o, 0);
    chk("reset w_ready_o", w_ready_o, 0);
    chk("reset w_last_o", w_last_o, 0);
    chk("reset w_data_o", w_data_o, 0);
    chk("reset busy_o", busy_o, 0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;

    for (int r = 0; r < 17; r++) begin
      aw_valid_i = tbl[r].awv;
      aw_ready_i = tbl[r].awr;
      w_valid_i  = tbl[r].wv;
      w_last_i   = tbl[r].wl;
      w_ready_i  = tbl[r].wr;
      flush_i    = tbl[r].fl;
      #1;
      exp_aw = (tbl[r].e_idx < 0) ? '0 : aw_pay(tbl[r].e_idx);
      chk($sformatf("row%0d aw_valid_o", r), aw_valid_o, tbl[r].e_awv);
      chk($sformatf("row%0d aw_ready_o", r), aw_ready_o, tbl[r].e_awr);
      chk($sformatf("row%0d aw_data_o", r), aw_data_o, exp_aw);
      chk($sformatf("row%0d w_valid_o", r), w_valid_o, tbl[r].e_wv);
      chk($sformatf("row%0d w_ready_o", r), w_ready_o, tbl[r].e_wr);
      chk($sformatf("row%0d w_last_o", r), w_last_o, tbl[r].e_wl);
      chk($sformatf("row%0d busy_o", r), busy_o, tbl[r].e_busy);
      @(posedge clk_i); #1;
    end
    flush_i    = 1'b0;
    aw_valid_i = '0;
    aw_ready_i = 1'b0;

    // W ordering: grant 1 then 3, requester 3 offers W first and must wait.
    w_ready_i = 1'b0;
    w_valid_i = '0;
    w_last_i  = '0;
    set_w(1, 1, 0, 0);
    set_w(3, 1, 0, 0);
    #1;
    chk("w stall before aw", w_valid_o, 0);
    @(posedge clk_i); #1;
    w_ready_i = 1'b1;
    aw_valid_i = 4'b0010;
    aw_ready_i = 1'b1;
    aw_q.push_back(1);
    #1;
    if (aw_valid_o) chk("aw_sb data first", aw_data_o, aw_pay(aw_q.pop_front()));
    else chk("aw_sb valid first", aw_valid_o, 1);
    chk("no w on push-while-empty", w_valid_o, 0);
    @(posedge clk_i); #1;
    w_ready_i = 1'b0;
    do_aw(3);
    for (int b = 0; b < 4; b++) w_q.push_back({(b == 3) ? 1'b1 : 1'b0, w_pay(1, b)});
    for (int b = 0; b < 2; b++) w_q.push_back({(b == 1) ? 1'b1 : 1'b0, w_pay(3, b)});
    b1 = 0;
    b3 = 0;
    w_ready_i = 1'b1;
    for (int cyc = 0; cyc < 40 && w_q.size() > 0; cyc++) begin
      set_w(1, b1 < 4, b1, b1 == 3);
      set_w(3, b3 < 2, b3, b3 == 1);
      #1;
      if (w_valid_o && w_ready_i) begin
        ew = w_q.pop_front();
        chk("w_sb beat", {w_last_o, w_data_o}, ew);
      end
      if (w_ready_o[1] && w_valid_i[1]) b1++;
      if (w_ready_o[3] && w_valid_i[3]) b3++;
      @(posedge clk_i); #1;
    end
    chk("w_sb drained", w_q.size(), 0);
    w_valid_i = '0;
    w_last_i  = '0;
    #1;
    chk("busy after drain", busy_o, 0);

    // Async reset in the middle of a W beat.
    do_aw(2);
    aw_valid_i = 4'b1111;
    aw_ready_i = 1'b0;
    w_ready_i  = 1'b1;
    set_w(2, 1, 0, 0);
    #1;
    chk("pre-reset w_valid_o", w_valid_o, 1);
    rst_ni = 1'b0;
    #1;
    chk("async aw_valid_o", aw_valid_o, 0);
    chk("async aw_ready_o", aw_ready_o, 0);
    chk("async aw_data_o", aw_data_o, 0);
    chk("async w_valid_o", w_valid_o, 0);
    chk("async w_ready_o", w_ready_o, 0);
    chk("async w_last_o", w_last_o, 0);
    chk("async w_data_o", w_data_o, 0);
    chk("async busy_o", busy_o, 0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
